// File: rtl/cpu6502_alu_seq_pkg.sv
// Shared definitions for the sequential 6502-style ALU slice.
//   op_e    : 5-bit operation code, instruction bits {7:5,1:0}
//   FLAG_*  : bit positions inside the 4-bit {N,V,Z,C} flag vector
//   state_e : handshake FSM encoding
//   is_bcd_op() : true for the two codes that honour the D flag
package cpu6502_pkg;

  typedef enum logic [4:0] {
    OP_ORA = 5'b00001,
    OP_AND = 5'b00101,
    OP_EOR = 5'b01001,
    OP_ADC = 5'b01101,
    OP_STA = 5'b10001,
    OP_LDA = 5'b10101,
    OP_CMP = 5'b11001,
    OP_SBC = 5'b11101,
    OP_ASL = 5'b00010,
    OP_ROL = 5'b00110,
    OP_LSR = 5'b01010,
    OP_ROR = 5'b01110
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DADJ = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic is_bcd_op(input logic [4:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/cpu6502_alu_seq_if.sv
// Request/response bundle for cpu6502_alu_seq.
//   master : drives request (in_valid, operation, operands, flags_in, decimal)
//            and out_ready; observes in_ready and the response
//   slave  : the ALU side, the reverse directions
interface cpu6502_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       operation;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [3:0]       flags_in;
  logic             decimal;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags_out;
  logic             illegal;

  modport master (
    output in_valid, operation, operand1, operand2, flags_in, decimal, out_ready,
    input  in_ready, out_valid, result, flags_out, illegal
  );

  modport slave (
    input  in_valid, operation, operand1, operand2, flags_in, decimal, out_ready,
    output in_ready, out_valid, result, flags_out, illegal
  );
endinterface

// File: rtl/cpu6502_bcd_adjust.sv
// Combinational nibble-serial BCD add/subtract with 6502 decimal adjust.
//   a, b   : packed-BCD operands (b is the raw memory-side operand)
//   cin    : incoming carry (not-borrow for subtract)
//   sbc    : 1 = a - b, 0 = a + b
//   sum    : adjusted BCD result
//   cout   : final decimal carry / not-borrow
module cpu6502_bcd_adjust #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sbc,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic       c;
    logic [3:0] an;
    logic [3:0] bn;
    logic [4:0] s;
    // NOTE: every variable gets a value before any branch so the block can
    // never hold a stale value, which is what would otherwise infer a latch.
    c   = cin;
    an  = '0;
    bn  = '0;
    s   = '0;
    sum = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      an = a[4*i +: 4];
      bn = sbc ? ~b[4*i +: 4] : b[4*i +: 4];
      s  = {1'b0, an} + {1'b0, bn} + {4'b0, c};
      if (!sbc) begin
        // Digit overflow past 9 (or a real nibble carry) skips the six
        // unused codes; the adjusted value then always reaches bit 4.
        if (s > 5'd9) s = s + 5'd6;
        c = s[4];
      end else begin
        // Nibble borrow wrapped into the 10..15 range: pull it back by six.
        c = s[4];
        if (!c) s[3:0] = s[3:0] - 4'd6;
      end
      sum[4*i +: 4] = s[3:0];
    end
    cout = c;
  end

endmodule

// File: rtl/cpu6502_alu_seq.sv
// Sequential 6502-style ALU with valid/ready handshakes on both sides.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : cpu6502_alu_seq_if.slave (request in, result/flags/illegal out)
// Binary operations land in HOLD one cycle after acceptance; decimal
// ADC/SBC spend one extra cycle in DADJ for the nibble adjust.
module cpu6502_alu_seq
  import cpu6502_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DECIMAL_EN = 1
) (
  input logic              clk,
  input logic              reset,
  cpu6502_alu_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic             in_ready, out_valid, accept, is_dec;

  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             illegal_q;

  // Operands captured for the decimal adjust cycle.
  logic [WIDTH-1:0] dec_a_q, dec_b_q;
  logic             dec_c_q, dec_sbc_q;

  logic [WIDTH-1:0] b_eff, diff, alu_res;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_flags;
  logic             alu_illegal, upd_nz, cin;

  logic [WIDTH-1:0] bcd_res, dec_b_eff, dec_bin;
  logic             bcd_c;
  logic [3:0]       dec_flags;

  assign accept = bus.in_valid && in_ready;
  assign is_dec = (DECIMAL_EN != 0) && bus.decimal && is_bcd_op(bus.operation);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of process ordering.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_dec ? ST_DADJ : ST_HOLD;
      ST_DADJ: state_d = ST_HOLD;
      ST_HOLD: begin
        // in_ready follows out_ready here, so accept implies consumption.
        if (accept)             state_d = is_dec ? ST_DADJ : ST_HOLD;
        else if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: begin
        in_ready  = bus.out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- binary datapath ----------------
  assign cin   = bus.flags_in[FLAG_C];
  assign b_eff = (bus.operation == OP_SBC) ? ~bus.operand2 : bus.operand2;
  assign sum   = {1'b0, bus.operand1} + {1'b0, b_eff} + (WIDTH+1)'(cin);
  assign diff  = bus.operand1 - bus.operand2;

  always_comb begin
    alu_res     = '0;
    alu_flags   = bus.flags_in;
    alu_illegal = 1'b0;
    upd_nz      = 1'b1;
    case (bus.operation)
      OP_ORA: alu_res = bus.operand1 | bus.operand2;
      OP_AND: alu_res = bus.operand1 & bus.operand2;
      OP_EOR: alu_res = bus.operand1 ^ bus.operand2;
      OP_LDA: alu_res = bus.operand2;
      OP_STA: begin
        alu_res = bus.operand1;
        upd_nz  = 1'b0;
      end
      OP_CMP: begin
        alu_res           = bus.operand1;
        upd_nz            = 1'b0;
        alu_flags[FLAG_N] = diff[WIDTH-1];
        alu_flags[FLAG_Z] = (diff == '0);
        alu_flags[FLAG_C] = (bus.operand1 >= bus.operand2);
      end
      OP_ADC, OP_SBC: begin
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        // Overflow: both addends share a sign that the sum does not.
        alu_flags[FLAG_V] = (bus.operand1[WIDTH-1] ^ sum[WIDTH-1]) &
                            (b_eff[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_ASL: begin
        alu_res           = {bus.operand2[WIDTH-2:0], 1'b0};
        alu_flags[FLAG_C] = bus.operand2[WIDTH-1];
      end
      OP_ROL: begin
        alu_res           = {bus.operand2[WIDTH-2:0], cin};
        alu_flags[FLAG_C] = bus.operand2[WIDTH-1];
      end
      OP_LSR: begin
        alu_res           = {1'b0, bus.operand2[WIDTH-1:1]};
        alu_flags[FLAG_C] = bus.operand2[0];
      end
      OP_ROR: begin
        alu_res           = {cin, bus.operand2[WIDTH-1:1]};
        alu_flags[FLAG_C] = bus.operand2[0];
      end
      default: begin
        alu_illegal = 1'b1;
        upd_nz      = 1'b0;
      end
    endcase
    if (upd_nz) begin
      alu_flags[FLAG_N] = alu_res[WIDTH-1];
      alu_flags[FLAG_Z] = (alu_res == '0);
    end
  end

  // ---------------- decimal datapath ----------------
  cpu6502_bcd_adjust #(.WIDTH(WIDTH)) u_bcd (
    .a    (dec_a_q),
    .b    (dec_b_q),
    .cin  (dec_c_q),
    .sbc  (dec_sbc_q),
    .sum  (bcd_res),
    .cout (bcd_c)
  );

  // V is taken from the unadjusted binary sum, as the NMOS part does.
  assign dec_b_eff = dec_sbc_q ? ~dec_b_q : dec_b_q;
  assign dec_bin   = dec_a_q + dec_b_eff + WIDTH'(dec_c_q);

  always_comb begin
    dec_flags         = '0;
    dec_flags[FLAG_N] = bcd_res[WIDTH-1];
    dec_flags[FLAG_V] = (dec_a_q[WIDTH-1] ^ dec_bin[WIDTH-1]) &
                        (dec_b_eff[WIDTH-1] ^ dec_bin[WIDTH-1]);
    dec_flags[FLAG_Z] = (bcd_res == '0);
    dec_flags[FLAG_C] = bcd_c;
  end

  // ---------------- output / capture registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      dec_a_q   <= '0;
      dec_b_q   <= '0;
      dec_c_q   <= 1'b0;
      dec_sbc_q <= 1'b0;
    end else if (accept) begin
      if (is_dec) begin
        dec_a_q   <= bus.operand1;
        dec_b_q   <= bus.operand2;
        dec_c_q   <= cin;
        dec_sbc_q <= (bus.operation == OP_SBC);
      end else begin
        result_q  <= alu_res;
        flags_q   <= alu_flags;
        illegal_q <= alu_illegal;
      end
    end else if (state_q == ST_DADJ) begin
      result_q  <= bcd_res;
      flags_q   <= dec_flags;
      illegal_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.flags_out = flags_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_cpu6502_alu_seq.sv
// Directed self-checking bench for cpu6502_alu_seq (8-bit and 16-bit builds).
module tb_cpu6502_alu_seq;
  import cpu6502_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  cpu6502_alu_seq_if #(.WIDTH(8))  bus8 ();
  cpu6502_alu_seq_if #(.WIDTH(16)) bus16 ();

  cpu6502_alu_seq #(.WIDTH(8), .DECIMAL_EN(1)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave)
  );
  cpu6502_alu_seq #(.WIDTH(16), .DECIMAL_EN(1)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave)
  );

  always #5 clk = ~clk;

  // One directed vector: stimulus and hand-computed response. Flags {N,V,Z,C}.
  typedef struct packed {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
    logic       d;
    logic [7:0] r;
    logic [3:0] fo;
    logic       ill;
    logic [3:0] lat;
  } vec_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic        d;
    logic [15:0] r;
    logic [3:0]  fo;
    logic [3:0]  lat;
  } vec16_t;

  // Present a request at a negedge; it is accepted on the following posedge.
  task automatic send8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] f, input logic d);
    @(negedge clk);
    bus8.operation = op;
    bus8.operand1  = a;
    bus8.operand2  = b;
    bus8.flags_in  = f;
    bus8.decimal   = d;
    bus8.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
  endtask

  // Cycles from acceptance to out_valid, sampled on negedges; 99 = timed out.
  task automatic wait8(output int lat);
    lat = 99;
    for (int i = 1; i <= 8 && lat == 99; i++) begin
      @(negedge clk);
      if (bus8.out_valid) lat = i;
    end
  endtask

  task automatic consume8();
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1 bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", bus8.out_valid); end
    n_cmp++;
    if (bus8.result !== 8'h00) begin n_err++; $display("FAIL reset result got %h want 00", bus8.result); end
    n_cmp++;
    if (bus8.flags_out !== 4'h0) begin n_err++; $display("FAIL reset flags got %b want 0000", bus8.flags_out); end
    n_cmp++;
    if (bus8.illegal !== 1'b0) begin n_err++; $display("FAIL reset illegal got %b want 0", bus8.illegal); end
    n_cmp++;
    reset = 1'b0;
    @(negedge clk);
    if (bus8.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b want 1", bus8.in_ready); end
    n_cmp++;
  endtask

  task automatic test_binary_ops();
    vec_t v[12];
    int   lat;
    v[0]  = '{OP_ADC, 8'h50, 8'h50, 4'b0000, 1'b0, 8'hA0, 4'b1100, 1'b0, 4'd1};
    v[1]  = '{OP_CMP, 8'h40, 8'h40, 4'b0100, 1'b0, 8'h40, 4'b0111, 1'b0, 4'd1};
    v[2]  = '{OP_ROR, 8'h33, 8'h01, 4'b0001, 1'b0, 8'h80, 4'b1001, 1'b0, 4'd1};
    v[3]  = '{OP_ASL, 8'h00, 8'h81, 4'b0000, 1'b0, 8'h02, 4'b0001, 1'b0, 4'd1};
    v[4]  = '{OP_LSR, 8'h00, 8'h01, 4'b0000, 1'b0, 8'h00, 4'b0011, 1'b0, 4'd1};
    v[5]  = '{OP_ROL, 8'h00, 8'h80, 4'b0000, 1'b0, 8'h00, 4'b0011, 1'b0, 4'd1};
    v[6]  = '{OP_EOR, 8'hFF, 8'h0F, 4'b0000, 1'b0, 8'hF0, 4'b1000, 1'b0, 4'd1};
    v[7]  = '{OP_STA, 8'h5C, 8'h99, 4'b1011, 1'b0, 8'h5C, 4'b1011, 1'b0, 4'd1};
    v[8]  = '{OP_AND, 8'hF0, 8'h3C, 4'b0000, 1'b1, 8'h30, 4'b0000, 1'b0, 4'd1};
    v[9]  = '{OP_SBC, 8'h00, 8'h01, 4'b0001, 1'b0, 8'hFF, 4'b1000, 1'b0, 4'd1};
    v[10] = '{OP_ORA, 8'h00, 8'h00, 4'b1101, 1'b0, 8'h00, 4'b0111, 1'b0, 4'd1};
    v[11] = '{OP_CMP, 8'h10, 8'h20, 4'b0000, 1'b0, 8'h10, 4'b1000, 1'b0, 4'd1};
    for (int i = 0; i < 12; i++) begin
      send8(v[i].op, v[i].a, v[i].b, v[i].f, v[i].d);
      wait8(lat);
      if (lat !== int'(v[i].lat)) begin n_err++; $display("FAIL bin[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++;
      if (bus8.result !== v[i].r) begin n_err++; $display("FAIL bin[%0d] result got %h want %h", i, bus8.result, v[i].r); end
      n_cmp++;
      if (bus8.flags_out !== v[i].fo) begin n_err++; $display("FAIL bin[%0d] flags got %b want %b", i, bus8.flags_out, v[i].fo); end
      n_cmp++;
      consume8();
    end
  endtask

  task automatic test_decimal();
    vec_t v[4];
    int   lat;
    v[0] = '{OP_ADC, 8'h58, 8'h46, 4'b0001, 1'b1, 8'h05, 4'b0101, 1'b0, 4'd2};
    v[1] = '{OP_SBC, 8'h12, 8'h21, 4'b0001, 1'b1, 8'h91, 4'b1000, 1'b0, 4'd2};
    v[2] = '{OP_ADC, 8'h99, 8'h01, 4'b0000, 1'b1, 8'h00, 4'b0011, 1'b0, 4'd2};
    v[3] = '{OP_SBC, 8'h00, 8'h01, 4'b0001, 1'b1, 8'h99, 4'b1000, 1'b0, 4'd2};
    for (int i = 0; i < 4; i++) begin
      send8(v[i].op, v[i].a, v[i].b, v[i].f, v[i].d);
      wait8(lat);
      if (lat !== int'(v[i].lat)) begin n_err++; $display("FAIL dec[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++;
      if (bus8.result !== v[i].r) begin n_err++; $display("FAIL dec[%0d] result got %h want %h", i, bus8.result, v[i].r); end
      n_cmp++;
      if (bus8.flags_out !== v[i].fo) begin n_err++; $display("FAIL dec[%0d] flags got %b want %b", i, bus8.flags_out, v[i].fo); end
      n_cmp++;
      consume8();
    end
  endtask

  task automatic test_illegal();
    vec_t v[3];
    int   lat;
    v[0] = '{5'b00000, 8'h12, 8'h34, 4'b1010, 1'b0, 8'h00, 4'b1010, 1'b1, 4'd1};
    v[1] = '{5'b11110, 8'h12, 8'h34, 4'b0101, 1'b1, 8'h00, 4'b0101, 1'b1, 4'd1};
    v[2] = '{OP_LDA,   8'h00, 8'h01, 4'b0000, 1'b0, 8'h01, 4'b0000, 1'b0, 4'd1};
    for (int i = 0; i < 3; i++) begin
      send8(v[i].op, v[i].a, v[i].b, v[i].f, v[i].d);
      wait8(lat);
      if (lat !== int'(v[i].lat)) begin n_err++; $display("FAIL ill[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++;
      if (bus8.illegal !== v[i].ill) begin n_err++; $display("FAIL ill[%0d] illegal got %b want %b", i, bus8.illegal, v[i].ill); end
      n_cmp++;
      if (bus8.result !== v[i].r) begin n_err++; $display("FAIL ill[%0d] result got %h want %h", i, bus8.result, v[i].r); end
      n_cmp++;
      if (bus8.flags_out !== v[i].fo) begin n_err++; $display("FAIL ill[%0d] flags got %b want %b", i, bus8.flags_out, v[i].fo); end
      n_cmp++;
      consume8();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals  [4];
    logic [3:0] flags [4];
    vals[0] = 8'h00; flags[0] = 4'b0010;
    vals[1] = 8'h80; flags[1] = 4'b1000;
    vals[2] = 8'h7F; flags[2] = 4'b0000;
    vals[3] = 8'h11; flags[3] = 4'b0000;
    bus8.out_ready = 1'b1;
    bus8.operation = OP_LDA;
    bus8.operand1  = 8'h00;
    bus8.flags_in  = 4'b0000;
    bus8.decimal   = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (bus8.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] out_valid got %b want 1", i, bus8.out_valid); end
        n_cmp++;
        if (bus8.result !== vals[i-1]) begin n_err++; $display("FAIL b2b[%0d] result got %h want %h", i, bus8.result, vals[i-1]); end
        n_cmp++;
        if (bus8.flags_out !== flags[i-1]) begin n_err++; $display("FAIL b2b[%0d] flags got %b want %b", i, bus8.flags_out, flags[i-1]); end
        n_cmp++;
      end
      if (bus8.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] in_ready got %b want 1", i, bus8.in_ready); end
      n_cmp++;
      if (i < 4) begin
        bus8.operand2 = vals[i];
        bus8.in_valid = 1'b1;
      end else begin
        bus8.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b drain out_valid got %b want 0", bus8.out_valid); end
    n_cmp++;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat;
    send8(OP_LDA, 8'h00, 8'h5A, 4'b0000, 1'b0);
    wait8(lat);
    if (lat !== 1) begin n_err++; $display("FAIL stall latency got %0d want 1", lat); end
    n_cmp++;
    bus8.operand2 = 8'hA5;
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus8.out_valid !== 1'b1) begin n_err++; $display("FAIL stall[%0d] out_valid got %b want 1", i, bus8.out_valid); end
      n_cmp++;
      if (bus8.result !== 8'h5A) begin n_err++; $display("FAIL stall[%0d] result got %h want 5a", i, bus8.result); end
      n_cmp++;
      if (bus8.in_ready !== 1'b0) begin n_err++; $display("FAIL stall[%0d] in_ready got %b want 0", i, bus8.in_ready); end
      n_cmp++;
      @(negedge clk);
    end
    bus8.out_ready = 1'b1;
    #1;
    if (bus8.in_ready !== 1'b1) begin n_err++; $display("FAIL stall release in_ready got %b want 1", bus8.in_ready); end
    n_cmp++;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b0;
    @(negedge clk);
    if (bus8.result !== 8'hA5 || bus8.out_valid !== 1'b1) begin
      n_err++; $display("FAIL stall next result got %h/%b want a5/1", bus8.result, bus8.out_valid);
    end
    n_cmp++;
    consume8();
  endtask

  task automatic test_reset_in_dadj();
    int lat;
    send8(OP_ADC, 8'h58, 8'h46, 4'b0001, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_dadj out_valid got %b want 0", bus8.out_valid); end
    n_cmp++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_dadj[%0d] out_valid got %b want 0", i, bus8.out_valid); end
      n_cmp++;
    end
    if (bus8.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_dadj in_ready got %b want 1", bus8.in_ready); end
    n_cmp++;
    if (bus8.result !== 8'h00 || bus8.flags_out !== 4'h0) begin
      n_err++; $display("FAIL rst_dadj cleared got %h/%b want 00/0000", bus8.result, bus8.flags_out);
    end
    n_cmp++;
    send8(OP_LDA, 8'h00, 8'h77, 4'b0000, 1'b0);
    wait8(lat);
    if (lat !== 1 || bus8.result !== 8'h77) begin
      n_err++; $display("FAIL rst_dadj recover got lat %0d result %h want 1/77", lat, bus8.result);
    end
    n_cmp++;
    consume8();
  endtask

  task automatic test_width16();
    vec16_t v[2];
    int     lat;
    v[0] = '{OP_ADC, 16'h9999, 16'h0001, 4'b0000, 1'b1, 16'h0000, 4'b0011, 4'd2};
    v[1] = '{OP_ADC, 16'h7FFF, 16'h0001, 4'b0000, 1'b0, 16'h8000, 4'b1100, 4'd1};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus16.operation = v[i].op;
      bus16.operand1  = v[i].a;
      bus16.operand2  = v[i].b;
      bus16.flags_in  = v[i].f;
      bus16.decimal   = v[i].d;
      bus16.in_valid  = 1'b1;
      @(posedge clk);
      #1 bus16.in_valid = 1'b0;
      lat = 99;
      for (int k = 1; k <= 8 && lat == 99; k++) begin
        @(negedge clk);
        if (bus16.out_valid) lat = k;
      end
      if (lat !== int'(v[i].lat)) begin n_err++; $display("FAIL w16[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++;
      if (bus16.result !== v[i].r) begin n_err++; $display("FAIL w16[%0d] result got %h want %h", i, bus16.result, v[i].r); end
      n_cmp++;
      if (bus16.flags_out !== v[i].fo) begin n_err++; $display("FAIL w16[%0d] flags got %b want %b", i, bus16.flags_out, v[i].fo); end
      n_cmp++;
      bus16.out_ready = 1'b1;
      @(posedge clk);
      #1 bus16.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus8.in_valid   = 1'b0;
    bus8.out_ready  = 1'b0;
    bus8.operation  = '0;
    bus8.operand1   = '0;
    bus8.operand2   = '0;
    bus8.flags_in   = '0;
    bus8.decimal    = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    bus16.operation = '0;
    bus16.operand1  = '0;
    bus16.operand2  = '0;
    bus16.flags_in  = '0;
    bus16.decimal   = 1'b0;

    test_reset();
    test_binary_ops();
    test_decimal();
    test_illegal();
    test_back_to_back();
    test_stall();
    test_reset_in_dadj();
    test_width16();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu6502_alu_seq.md
CPU6502_ALU_SEQ -- requirements
Module: cpu6502_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits; legal values are multiples of 4, minimum 4.
REQ-002 SHALL have parameter DECIMAL_EN, default 1; when 1, decimal-mode ADC/SBC is supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted on the cycle where in_valid && in_ready.
REQ-007 operation  input  5  opcode bits {7:5,1:0}.
REQ-008 operand1 / operand2  input  WIDTH  accumulator-side / memory-side operand.
REQ-009 flags_in  input  4  {N,V,Z,C} before the operation.
REQ-010 decimal  input  1  D flag; selects BCD for ADC/SBC.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-013 result  output  WIDTH  operation result.
REQ-014 flags_out  output  4  {N,V,Z,C} after the operation.
REQ-015 illegal  output  1  held request carried an unsupported operation code.

Function
REQ-016 Supported codes: ORA 00001, AND 00101, EOR 01001, ADC 01101, STA 10001, LDA 10101, CMP 11001, SBC 11101, ASL 00010, ROL 00110, LSR 01010, ROR 01110.
REQ-017 Shifts SHALL operate on operand2; ROL/ROR shift C in; C takes the bit shifted out.
REQ-018 ORA/AND/EOR/LDA SHALL update N,Z; STA SHALL pass result=operand1 and all flags unchanged.
REQ-019 CMP SHALL output result=operand1; C = operand1 >= operand2 (unsigned); N,Z from operand1 - operand2; V unchanged.
REQ-020 ADC SHALL compute operand1 + operand2 + C at WIDTH+1 bits; SBC SHALL compute operand1 + ~operand2 + C.
REQ-021 Binary ADC/SBC: C = bit WIDTH; V = signed overflow; N = result MSB; Z = result==0.
REQ-022 Decimal ADC/SBC (decimal && DECIMAL_EN): per nibble from LSB, ADC adds 6 when digit>9 or nibble carry; SBC subtracts 6 when nibble borrow; C = final decimal carry / not-borrow.
REQ-023 Decimal V SHALL come from the binary intermediate sum; N and Z SHALL come from the adjusted result.
REQ-024 Unsupported code: result 0, flags_out = flags_in, illegal=1, normal handshake.
REQ-025 FSM states: IDLE, DADJ, HOLD.
REQ-026 IDLE: in_ready=1; accepted binary op -> HOLD; accepted decimal ADC/SBC -> DADJ.
REQ-027 DADJ: in_ready=0, out_valid=0; next cycle -> HOLD with adjusted result.
REQ-028 HOLD: out_valid=1; result/flags/illegal stable until consumed; in_ready = out_ready.
REQ-029 HOLD with out_ready && !in_valid -> IDLE; with out_ready && in_valid, new request accepted in the same cycle (binary -> HOLD, decimal -> DADJ).
REQ-030 Latency: binary op 1 cycle, decimal op 2 cycles, acceptance to out_valid; binary throughput 1 per cycle.
REQ-031 decimal SHALL be ignored when DECIMAL_EN=0 or for non-ADC/SBC codes.

Reset
REQ-032 Reset SHALL force IDLE, out_valid=0, result=0, flags_out=0, illegal=0; in_ready=1 after release.
REQ-033 Reset asserted during DADJ or HOLD SHALL discard the in-flight operation with no output.

Structure
REQ-034 Operation codes, flag bit indices and FSM state encoding SHALL live in shared package cpu6502_pkg.
REQ-035 Nibble decimal adjust SHALL be one sub-module, cpu6502_bcd_adjust, parameterised by WIDTH, combinational.

Verification
REQ-036 ADC 0x50+0x50, C=0, D=0 -> result 0xA0, N=1 V=1 Z=0 C=0, out_valid 1 cycle after accept.
REQ-037 ADC 0x58+0x46, C=1, D=1 -> result 0x05, C=1, out_valid 2 cycles after accept; SBC 0x12-0x21, C=1, D=1 -> 0x91, C=0.
REQ-038 CMP 0x40 vs 0x40 -> result 0x40, Z=1 C=1 N=0; ROR 0x01 with C=1 -> 0x80, C=1, N=1.
REQ-039 Back-to-back LDA stream, out_ready=1 -> one result per cycle; out_ready=0 for 3 cycles -> result held, in_ready=0.
REQ-040 Code 00000 -> illegal=1, result 0, flags_out=flags_in; reset asserted in DADJ -> out_valid stays 0, IDLE after release.
REQ-041 WIDTH=16: ADC D=1 0x9999+0x0001 -> 0x0000, C=1, Z=1.
